hs_arbiter2: RTL and testbench
==============================

Name: hs_arbiter2

Overview:
Two-input round-robin merge for the four-phase request/acknowledge channel used by the FIFO stages. Two upstream producers each drive an 8-bit word with a request-read/ack-read pair. The block picks one winner, captures its word, and replays it downstream on a request-write/ack-write pair into the head of a FIFO stage chain. It is a Moore controller: all handshake outputs decode from registered state.

Parameters:
- WIDTH, 8, data word width for din0, din1 and dout.
- CNT_W, 16, width of the per-port grant counters (used only with the optional feature).

Ports:
- clk    input   1      rising-edge clock
- reset  input   1      asynchronous, active-low reset (0 = reset asserted)
- din0   input   WIDTH  port 0 data, valid while rr0 is high
- rr0    input   1      port 0 request read
- ar0    output  1      port 0 ack read
- din1   input   WIDTH  port 1 data, valid while rr1 is high
- rr1    input   1      port 1 request read
- ar1    output  1      port 1 ack read
- dout   output  WIDTH  registered captured word
- rw     output  1      downstream request write
- aw     input   1      downstream ack write
- gnt    output  1      index of the current or last-served port
- cnt0   output  CNT_W  port 0 grant count (only when the optional feature is compiled in)
- cnt1   output  CNT_W  port 1 grant count (only when the optional feature is compiled in)

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE, dreg = 0, sel = 0, last = 1.
  - ar0 = ar1 = rw = 0, dout = 0, gnt = 0.
  - Counters = 0.
  - Reset mid-transfer abandons the transfer; no output glitches high on release.
- IDLE:
  - All handshake outputs are 0.
  - If neither rr0 nor rr1 is high, stay in IDLE.
  - If exactly one is high, sel <= that port.
  - If both are high, sel <= ~last (round-robin; the first contest after reset goes to port 0).
  - Whenever any request is high, next state is CAP.
- CAP:
  - ar[sel] = 1; the other port's ar stays 0.
  - dreg <= din[sel] every cycle.
  - When rr[sel] = 0, go to SEND. dreg then holds the last value sampled while rr[sel] was high, because the update is gated by rr[sel].
- SEND:
  - rw = 1, dout = dreg, stable.
  - When aw = 1, go to REL.
- REL:
  - rw = 0.
  - When aw = 0: go to IDLE, last <= sel, and increment cnt[sel] if the feature is compiled in.
- Latency:
  - rr rising to ar rising: 1 clock.
  - Minimum full cycle: 4 clocks when upstream and downstream respond in the same cycle.
- Requests on the losing port are never dropped; they stay pending and win the next IDLE evaluation.
- The block never acknowledges both ports at the same time, and never asserts ar in any state other than CAP.
- Protocol violations:
  - A request on the non-selected port while busy is ignored until IDLE.
  - aw high while in IDLE or CAP is ignored.
- gnt = sel, registered.
- Counters wrap modulo 2^CNT_W with no saturation.

Optional Feature:
- Macro: HS_ARB_STATS_EN.
- Defined: cnt0 and cnt1 ports exist and count completed transfers per port. They increment on the REL-to-IDLE transition.
- Undefined: the cnt ports and counter registers are absent. All other behaviour is identical.

Decomposition:
- Shared package hs_pkg holds:
  - state encoding localparams: IDLE = 2'b00, CAP = 2'b01, SEND = 2'b10, REL = 2'b11 (the same four-phase encoding as the FIFO stages);
  - WIDTH default.
- One sub-module, hs_rr_pick2: combinational round-robin picker. Inputs are req[1:0] and last; outputs are valid and sel. It is reusable for wider arbiters later.

Test Plan:
1. Reset held low for 3 clocks with rr0 = 1 and aw = 1, then released → during reset ar0 = ar1 = rw = 0 and dout = 0; one clock after release ar0 = 1 and gnt = 0.
2. Single transfer: rr0 = 1 with din0 = 8'hA5, drop rr0 when ar0 = 1, testbench answers aw on rw → dout = 8'hA5 while rw = 1; cycle returns to IDLE; ar1 never high.
3. Contention: rr0 = rr1 = 1 continuously, din0 = 8'h11, din1 = 8'h22, each upstream handshake completed → grants alternate 0,1,0,1; dout sequence is 11, 22, 11, 22.
4. Slow downstream: aw is delayed 10 clocks after rw rises → rw stays high and dout stable for all 10 clocks; ar0 and ar1 stay 0 throughout.
5. Reset asserted while in SEND with dout = 8'h3C → rw drops asynchronously and dout = 0; after release, state is IDLE with last = 1.
6. With HS_ARB_STATS_EN: 5 transfers on port 0 and 3 on port 1 → cnt0 = 5, cnt1 = 3. With CNT_W = 2 and 5 transfers, cnt0 wraps to 1.

Source files
------------

// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hs_pkg
//  Description : Shared definitions for the four-phase handshake blocks.
//                Holds the state encoding (identical to the FIFO stages) and
//                the default data word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

  // Default data word width for the handshake channel
  localparam int c_hs_width = 8;

  // Four-phase state encoding shared with the FIFO stages
  localparam logic [1:0] c_st_idle = 2'b00;
  localparam logic [1:0] c_st_cap  = 2'b01;
  localparam logic [1:0] c_st_send = 2'b10;
  localparam logic [1:0] c_st_rel  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = c_st_idle,
    CAP  = c_st_cap,
    SEND = c_st_send,
    REL  = c_st_rel
  } hs_state_t;

endpackage
`default_nettype wire

// File: rtl/hs_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : hs_rr_pick2
//  Description : Combinational two-way round-robin picker. A lone request wins
//                outright; with both requesting, the port that was not served
//                last wins.
//  Ports       : req   [1:0] in  - request vector (bit i = port i)
//                last        in  - index of the last-served port
//                valid       out - at least one request is present
//                sel         out - index of the winning port
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       sel
);

  always_comb begin
    valid = |req;
    sel   = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last;
      default: sel = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hs_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : hs_arbiter2
//  Description : Two-input round-robin merge for the four-phase request/ack
//                channel. One upstream word is captured per transfer and
//                replayed downstream on rw/aw. Moore controller: every
//                handshake output decodes from registered state.
//  Ports       : clk          in  - rising-edge clock
//                reset        in  - asynchronous reset, active low
//                din0/din1    in  - upstream data words
//                rr0/rr1      in  - upstream request read
//                ar0/ar1      out - upstream ack read
//                dout         out - registered captured word
//                rw           out - downstream request write
//                aw           in  - downstream ack write
//                gnt          out - current or last-served port
//                cnt0/cnt1    out - per-port completed transfer counts
//  Options     : HS_ARB_STATS_EN - when defined, adds the CNT_W parameter,
//                the cnt0/cnt1 ports and their wrapping counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_arbiter2
  import hs_pkg::*;
#(
  parameter int WIDTH = c_hs_width
`ifdef HS_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din0,
  input  logic             rr0,
  output logic             ar0,
  input  logic [WIDTH-1:0] din1,
  input  logic             rr1,
  output logic             ar1,
  output logic [WIDTH-1:0] dout,
  output logic             rw,
  input  logic             aw,
  output logic             gnt
`ifdef HS_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  hs_state_t        r_state;
  hs_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_dreg;
  logic             r_sel;
  logic             r_last;

  logic             w_pick_valid;
  logic             w_pick_sel;
  logic             w_rr_sel;
  logic [WIDTH-1:0] w_din_sel;
  logic             w_ar0;
  logic             w_ar1;
  logic             w_rw;
  logic             w_done;

  // Request and data of the currently selected port
  assign w_rr_sel  = r_sel ? rr1  : rr0;
  assign w_din_sel = r_sel ? din1 : din0;

  hs_rr_pick2 u_pick (
    .req   ({rr1, rr0}),
    .last  (r_last),
    .valid (w_pick_valid),
    .sel   (w_pick_sel)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ar0       = 1'b0;
    w_ar1       = 1'b0;
    w_rw        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = CAP;
        end
      end
      CAP: begin
        w_ar0 = ~r_sel;
        w_ar1 = r_sel;
        if (!w_rr_sel) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_rw = 1'b1;
        if (aw) begin
          w_state_nxt = REL;
        end
      end
      REL: begin
        if (!aw) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: selection, capture register, round-robin history.
  // last resets to 1 so the first contest after reset goes to port 0.
  // Capture is gated by rr[sel] so dreg keeps the final word sampled while the
  // producer still held its request.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dreg <= '0;
      r_sel  <= 1'b0;
      r_last <= 1'b1;
    end else begin
      if (r_state == IDLE && w_pick_valid) begin
        r_sel <= w_pick_sel;
      end
      if (r_state == CAP && w_rr_sel) begin
        r_dreg <= w_din_sel;
      end
      if (w_done) begin
        r_last <= r_sel;
      end
    end
  end

  assign ar0  = w_ar0;
  assign ar1  = w_ar1;
  assign rw   = w_rw;
  assign dout = r_dreg;
  assign gnt  = r_sel;

`ifdef HS_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Completed-transfer counters, bumped on REL -> IDLE, wrapping freely
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_done) begin
      if (r_sel) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end else begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hs_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hs_arbiter2
//  Description : Self-checking bench for hs_arbiter2. A table of directed
//                vectors covers reset, single transfers and contention; short
//                hand-written sequences cover slow downstream, asynchronous
//                reset mid-transfer and (with HS_ARB_STATS_EN) the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_arbiter2;

  logic       clk;
  logic       reset;
  logic [7:0] din0;
  logic [7:0] din1;
  logic       rr0;
  logic       rr1;
  logic       aw;
  logic       ar0;
  logic       ar1;
  logic       rw;
  logic [7:0] dout;
  logic       gnt;
`ifdef HS_ARB_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic        ar0_w2;
  logic        ar1_w2;
  logic        rw_w2;
  logic [7:0]  dout_w2;
  logic        gnt_w2;
  logic [1:0]  cnt0_w2;
  logic [1:0]  cnt1_w2;
`endif

  int n_checks;
  int n_errors;

  hs_arbiter2 dut (
    .clk   (clk),
    .reset (reset),
    .din0  (din0),
    .rr0   (rr0),
    .ar0   (ar0),
    .din1  (din1),
    .rr1   (rr1),
    .ar1   (ar1),
    .dout  (dout),
    .rw    (rw),
    .aw    (aw),
    .gnt   (gnt)
`ifdef HS_ARB_STATS_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

`ifdef HS_ARB_STATS_EN
  // Narrow-counter copy sharing the same stimulus, for the wrap check
  hs_arbiter2 #(.CNT_W(2)) dut_w2 (
    .clk   (clk),
    .reset (reset),
    .din0  (din0),
    .rr0   (rr0),
    .ar0   (ar0_w2),
    .din1  (din1),
    .rr1   (rr1),
    .ar1   (ar1_w2),
    .dout  (dout_w2),
    .rw    (rw_w2),
    .aw    (aw),
    .gnt   (gnt_w2),
    .cnt0  (cnt0_w2),
    .cnt1  (cnt1_w2)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic       rr0;
    logic       rr1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       aw;
    logic       ar0;
    logic       ar1;
    logic       rw;
    logic [7:0] dout;
    logic       gnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic q0, input logic q1,
                     input logic [7:0] d0, input logic [7:0] d1, input logic a,
                     input logic e_ar0, input logic e_ar1, input logic e_rw,
                     input logic [7:0] e_dout, input logic e_gnt);
    vec_t v;
    v.rst_n = r;   v.rr0 = q0;    v.rr1 = q1;   v.d0 = d0;     v.d1 = d1;
    v.aw = a;      v.ar0 = e_ar0; v.ar1 = e_ar1; v.rw = e_rw;
    v.dout = e_dout; v.gnt = e_gnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded four-phase transfer on one port, used for the counter test
  task automatic xfer(input logic p, input logic [7:0] d);
    int k;
    if (p) begin rr1 = 1'b1; din1 = d; end
    else   begin rr0 = 1'b1; din0 = d; end
    k = 0;
    do begin step(); k++; end while (!(p ? ar1 : ar0) && k < 8);
    chk($sformatf("xfer%0d.ar", p), p ? ar1 : ar0, 1);
    step();
    rr0 = 1'b0;
    rr1 = 1'b0;
    k = 0;
    do begin step(); k++; end while (!rw && k < 8);
    chk($sformatf("xfer%0d.rw", p), rw, 1);
    chk($sformatf("xfer%0d.dout", p), dout, d);
    aw = 1'b1;
    k = 0;
    do begin step(); k++; end while (rw && k < 8);
    chk($sformatf("xfer%0d.rw_low", p), rw, 0);
    aw = 1'b0;
    step();
  endtask

  // Mutual exclusion of the two acks, sampled away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      n_checks++;
      if (ar0 && ar1) begin
        n_errors++;
        $display("FAIL ack_exclusive: ar0=%0b ar1=%0b, expected not both (t=%0t)", ar0, ar1, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    rr0 = 1'b0; rr1 = 1'b0; aw = 1'b0;
    din0 = 8'h00; din1 = 8'h00;

    // ---- reset held with rr0 and aw high, then single transfer on port 0
    add(0,1,0,8'h00,8'h00,1, 0,0,0,8'h00,0);
    add(0,1,0,8'h00,8'h00,1, 0,0,0,8'h00,0);
    add(0,1,0,8'h00,8'h00,1, 0,0,0,8'h00,0);
    add(1,1,0,8'hA5,8'h00,0, 1,0,0,8'h00,0);
    add(1,1,0,8'hA5,8'h00,0, 1,0,0,8'hA5,0);
    add(1,0,0,8'hA5,8'h00,0, 0,0,1,8'hA5,0);
    add(1,0,0,8'hA5,8'h00,1, 0,0,0,8'hA5,0);
    add(1,0,0,8'hA5,8'h00,0, 0,0,0,8'hA5,0);
    // aw in IDLE is ignored; then single request on port 1
    add(1,0,0,8'h00,8'h00,1, 0,0,0,8'hA5,0);
    add(1,0,1,8'h00,8'h77,0, 0,1,0,8'hA5,1);
    add(1,0,1,8'h00,8'h77,0, 0,1,0,8'h77,1);
    add(1,0,0,8'h00,8'h77,0, 0,0,1,8'h77,1);
    add(1,0,0,8'h00,8'h77,1, 0,0,0,8'h77,1);
    add(1,0,0,8'h00,8'h77,0, 0,0,0,8'h77,1);
    // ---- fresh reset, then continuous contention: grants 0,1,0,1
    add(0,0,0,8'h00,8'h00,0, 0,0,0,8'h00,0);
    add(1,1,1,8'h11,8'h22,0, 1,0,0,8'h00,0);
    add(1,1,1,8'h11,8'h22,0, 1,0,0,8'h11,0);
    add(1,0,1,8'h11,8'h22,0, 0,0,1,8'h11,0);
    add(1,0,1,8'h11,8'h22,1, 0,0,0,8'h11,0);
    add(1,1,1,8'h11,8'h22,0, 0,0,0,8'h11,0);
    add(1,1,1,8'h11,8'h22,0, 0,1,0,8'h11,1);
    add(1,1,1,8'h11,8'h22,1, 0,1,0,8'h22,1);  // aw in CAP ignored
    add(1,1,0,8'h11,8'h22,0, 0,0,1,8'h22,1);
    add(1,1,0,8'h11,8'h22,1, 0,0,0,8'h22,1);
    add(1,1,1,8'h11,8'h22,0, 0,0,0,8'h22,1);
    add(1,1,1,8'h11,8'h22,0, 1,0,0,8'h22,0);
    add(1,1,1,8'h11,8'h22,0, 1,0,0,8'h11,0);
    add(1,0,1,8'h11,8'h22,0, 0,0,1,8'h11,0);
    add(1,0,1,8'h11,8'h22,1, 0,0,0,8'h11,0);
    add(1,1,1,8'h11,8'h22,0, 0,0,0,8'h11,0);
    add(1,1,1,8'h11,8'h22,0, 0,1,0,8'h11,1);
    add(1,1,1,8'h11,8'h22,0, 0,1,0,8'h22,1);
    add(1,1,0,8'h11,8'h22,0, 0,0,1,8'h22,1);
    add(1,0,0,8'h11,8'h22,1, 0,0,0,8'h22,1);
    add(1,0,0,8'h11,8'h22,0, 0,0,0,8'h22,1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n;
      rr0   = vecs[i].rr0;
      rr1   = vecs[i].rr1;
      din0  = vecs[i].d0;
      din1  = vecs[i].d1;
      aw    = vecs[i].aw;
      step();
      chk($sformatf("v%0d.ar0", i),  ar0,  vecs[i].ar0);
      chk($sformatf("v%0d.ar1", i),  ar1,  vecs[i].ar1);
      chk($sformatf("v%0d.rw", i),   rw,   vecs[i].rw);
      chk($sformatf("v%0d.dout", i), dout, vecs[i].dout);
      chk($sformatf("v%0d.gnt", i),  gnt,  vecs[i].gnt);
    end

    // ---- slow downstream: aw held off for 10 clocks, port 1 pending meanwhile
    rr0 = 1'b1; din0 = 8'hC3;
    step();
    chk("slow.ar0", ar0, 1);
    step();
    rr0 = 1'b0;
    step();
    chk("slow.rw_rise", rw, 1);
    rr1 = 1'b1; din1 = 8'h96;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("slow%0d.rw", i),   rw,   1);
      chk($sformatf("slow%0d.dout", i), dout, 8'hC3);
      chk($sformatf("slow%0d.ar0", i),  ar0,  0);
      chk($sformatf("slow%0d.ar1", i),  ar1,  0);
    end
    aw = 1'b1;
    step();
    chk("slow.rw_fall", rw, 0);
    aw = 1'b0;
    step();
    chk("slow.idle_ar1", ar1, 0);
    step();
    chk("pending.ar1", ar1, 1);
    chk("pending.gnt", gnt, 1);
    step();
    rr1 = 1'b0;
    step();
    chk("pending.dout", dout, 8'h96);
    aw = 1'b1;
    step();
    aw = 1'b0;
    step();

    // ---- asynchronous reset while in SEND
    rr0 = 1'b1; din0 = 8'h3C;
    step();
    step();
    rr0 = 1'b0;
    step();
    chk("rst_send.rw_before", rw, 1);
    chk("rst_send.dout_before", dout, 8'h3C);
    #2 reset = 1'b0;
    #1;
    chk("rst_send.rw_async", rw, 0);
    chk("rst_send.dout_async", dout, 8'h00);
    step();
    step();
    reset = 1'b1;
    rr0 = 1'b1; rr1 = 1'b1; din0 = 8'h44; din1 = 8'h55;
    step();
    chk("rst_send.last_ar0", ar0, 1);
    chk("rst_send.last_gnt", gnt, 0);
    step();
    rr0 = 1'b0; rr1 = 1'b0;
    step();
    aw = 1'b1;
    step();
    aw = 1'b0;
    step();

`ifdef HS_ARB_STATS_EN
    // ---- counters: 5 transfers on port 0, 3 on port 1
    reset = 1'b0;
    step();
    chk("cnt.rst0", cnt0, 0);
    chk("cnt.rst1", cnt1, 0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 5; i++) xfer(1'b0, 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) xfer(1'b1, 8'h20 + 8'(i));
    chk("cnt.cnt0", cnt0, 5);
    chk("cnt.cnt1", cnt1, 3);
    chk("cnt.w2_cnt0_wrap", cnt0_w2, 1);
    chk("cnt.w2_cnt1", cnt1_w2, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
